// File: rtl/asg_seq_pkg.sv
// Shared widths, tick divider default and FSM encoding for the ASG sweep sequencer.
package asg_seq_pkg;

  localparam int DEF_NPTS_W   = 8;
  localparam int DEF_REP_W    = 16;
  localparam int DEF_DLY_W    = 32;
  localparam int DEF_TMO_W    = 24;
  localparam int DEF_TICK_DIV = 125;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_DELAY  = 3'd4,
    ST_FINISH = 3'd5
  } seq_state_t;

endpackage

// File: rtl/asg_us_tick.sv
// Microsecond prescaler: one-cycle tick every DIV cycles, phase reset by restart.
// Tick is decoded from the counter register; no backpressure.
module asg_us_tick #(
  parameter int DIV = 125
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !restart && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/asg_sweep_sequencer.sv
// Sweeps N points x R repetitions, pulsing measurement start and gating result writes.
// Start-to-meas_start latency one cycle; all outputs registered; waits on meas_done with optional timeout.
module asg_sweep_sequencer
  import asg_seq_pkg::*;
#(
  parameter int NPTS_W   = DEF_NPTS_W,
  parameter int REP_W    = DEF_REP_W,
  parameter int DLY_W    = DEF_DLY_W,
  parameter int TMO_W    = DEF_TMO_W,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic              dac_clk_i,
  input  logic              dac_rstn_i,
  input  logic              cfg_start_i,
  input  logic              cfg_abort_i,
  input  logic [NPTS_W-1:0] cfg_npts_i,
  input  logic [REP_W-1:0]  cfg_nrep_i,
  input  logic [DLY_W-1:0]  cfg_rdly_i,
  input  logic [TMO_W-1:0]  cfg_tmo_i,
  input  logic              meas_done_i,
  input  logic              meas_wr_i,
  output logic              meas_start_o,
  output logic              meas_abort_o,
  output logic              res_we_o,
  output logic [NPTS_W-1:0] res_addr_o,
  output logic [NPTS_W-1:0] point_idx_o,
  output logic [REP_W-1:0]  rep_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_tmo_o,
  output logic [2:0]        state_o
);

  seq_state_t        state;
  logic [NPTS_W-1:0] npts_q;
  logic [REP_W-1:0]  nrep_q;
  logic [DLY_W-1:0]  rdly_q;
  logic [DLY_W-1:0]  dly_cnt;
  logic [TMO_W-1:0]  tmo_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tick;

  // Prescaler is held in restart outside DELAY so every delay starts on a fresh 1 us boundary.
  asg_us_tick #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk    (dac_clk_i),
    .rst_n  (dac_rstn_i),
    .restart(state != ST_DELAY),
    .tick   (tick)
  );

  assign state_o = state;

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state        <= ST_IDLE;
      npts_q       <= '0;
      nrep_q       <= '0;
      rdly_q       <= '0;
      tmo_q        <= '0;
      dly_cnt      <= '0;
      tmo_cnt      <= '0;
      meas_start_o <= 1'b0;
      meas_abort_o <= 1'b0;
      res_we_o     <= 1'b0;
      res_addr_o   <= '0;
      point_idx_o  <= '0;
      rep_idx_o    <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_tmo_o    <= 1'b0;
    end else begin
      meas_start_o <= 1'b0;
      meas_abort_o <= 1'b0;
      done_o       <= 1'b0;
      res_we_o     <= meas_wr_i && (state == ST_WAIT || state == ST_NEXT);
      res_addr_o   <= point_idx_o;

      if (state != ST_IDLE && cfg_abort_i) begin
        state        <= ST_IDLE;
        busy_o       <= 1'b0;
        meas_abort_o <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cfg_start_i && !cfg_abort_i) begin
              npts_q      <= cfg_npts_i;
              nrep_q      <= (cfg_nrep_i == '0) ? REP_W'(1) : cfg_nrep_i;
              rdly_q      <= cfg_rdly_i;
              tmo_q       <= cfg_tmo_i;
              point_idx_o <= '0;
              rep_idx_o   <= '0;
              err_tmo_o   <= 1'b0;
              busy_o      <= 1'b1;
              if (cfg_npts_i == '0) begin
                state <= ST_FINISH;
              end else begin
                state        <= ST_LAUNCH;
                meas_start_o <= 1'b1;
              end
            end
          end

          ST_LAUNCH: begin
            tmo_cnt <= '0;
            state   <= ST_WAIT;
          end

          ST_WAIT: begin
            if (meas_done_i) begin
              state <= ST_NEXT;
            end else if (tmo_q != '0 && tmo_cnt == tmo_q - TMO_W'(1)) begin
              tmo_cnt      <= tmo_q;
              err_tmo_o    <= 1'b1;
              meas_abort_o <= 1'b1;
              state        <= ST_FINISH;
            end else if (tmo_q != '0 && tmo_cnt != tmo_q) begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end

          ST_NEXT: begin
            if (point_idx_o < npts_q - NPTS_W'(1)) begin
              point_idx_o  <= point_idx_o + NPTS_W'(1);
              meas_start_o <= 1'b1;
              state        <= ST_LAUNCH;
            end else if (rep_idx_o < nrep_q - REP_W'(1)) begin
              rep_idx_o   <= rep_idx_o + REP_W'(1);
              point_idx_o <= '0;
              if (rdly_q == '0) begin
                meas_start_o <= 1'b1;
                state        <= ST_LAUNCH;
              end else begin
                dly_cnt <= rdly_q;
                state   <= ST_DELAY;
              end
            end else begin
              state <= ST_FINISH;
            end
          end

          ST_DELAY: begin
            if (tick) begin
              if (dly_cnt <= DLY_W'(1)) begin
                dly_cnt      <= '0;
                meas_start_o <= 1'b1;
                state        <= ST_LAUNCH;
              end else begin
                dly_cnt <= dly_cnt - DLY_W'(1);
              end
            end
          end

          ST_FINISH: begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end

          default: begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/asg_sweep_sequencer.md
Name: asg_sweep_sequencer

Overview:
Sequences the chirp measurement datapath of one ASG channel over a sweep of N frequency points, repeated R times. Each repetition is separated by a programmable delay in 1 us units. The block pulses the measurement start for each point and waits for the measurement-finished pulse, with an optional timeout. It gates result-buffer writes so that only writes belonging to the active sweep reach the buffer, and it addresses those writes by point index. It sits between the system-bus configuration registers and the chirp control path / result buffer.

Parameters:
NPTS_W, 8, width of point count/index (result buffer holds 2^NPTS_W points per half)
REP_W, 16, width of repetition count
DLY_W, 32, width of inter-repetition delay (us)
TMO_W, 24, width of per-point timeout (clock cycles)
TICK_DIV, 125, clock cycles per 1 us tick (125 MHz)

Ports:
dac_clk_i  in  1  clock
dac_rstn_i  in  1  reset, asynchronous, active-low
cfg_start_i  in  1  start sweep (level sampled each cycle, acted on in IDLE)
cfg_abort_i  in  1  abort sweep
cfg_npts_i  in  NPTS_W  points per repetition
cfg_nrep_i  in  REP_W  repetitions (0 treated as 1)
cfg_rdly_i  in  DLY_W  delay between repetitions, us
cfg_tmo_i  in  TMO_W  per-point timeout, cycles (0 = disabled)
meas_done_i  in  1  measurement finished pulse from control path
meas_wr_i  in  1  result write strobe from control path
meas_start_o  out  1  one-cycle start pulse to control path
meas_abort_o  out  1  one-cycle abort pulse to control path
res_we_o  out  1  gated result-buffer write enable
res_addr_o  out  NPTS_W  result-buffer point address (= point_idx_o)
point_idx_o  out  NPTS_W  current point
rep_idx_o  out  REP_W  current repetition
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle sweep-complete pulse
err_tmo_o  out  1  sticky timeout flag, cleared on next accepted start
state_o  out  3  FSM state for debug

Behaviour:
- Reset: all outputs 0; FSM in IDLE; latched configuration 0.
- All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT, NEXT, DELAY, FINISH.
- IDLE:
  - cfg_start_i=1 and cfg_abort_i=0: latch npts, nrep (0 becomes 1), rdly and tmo; clear indices; clear err_tmo_o.
  - If latched npts=0, go to FINISH; otherwise go to LAUNCH.
- LAUNCH: meas_start_o=1 for exactly this cycle; timeout counter cleared; next state WAIT.
  - Latency: start sampled at cycle 0 gives meas_start_o and busy_o at cycle 1.
- WAIT:
  - meas_done_i=1: go to NEXT.
  - Else if tmo≠0 and the timeout counter reaches tmo: set err_tmo_o, pulse meas_abort_o, go to FINISH.
  - meas_done_i and timeout in the same cycle: done wins.
- NEXT:
  - point_idx < npts-1: point_idx+1, go to LAUNCH.
  - Else if rep_idx < nrep-1: rep_idx+1, point_idx=0, go to DELAY, or straight to LAUNCH if rdly=0.
  - Else go to FINISH.
- DELAY: tick prescaler restarts on entry. The block counts rdly ticks of TICK_DIV cycles each, then goes to LAUNCH. rdly=1 gives exactly 125 cycles in DELAY.
- FINISH: done_o=1 for one cycle; go to IDLE. busy_o drops in the same cycle it returns to IDLE.
- res_we_o = meas_wr_i registered, and only while in WAIT or NEXT. res_addr_o carries the point_idx of that write. Writes outside the sweep are dropped.
- Abort: cfg_abort_i in any non-IDLE state → IDLE next cycle, meas_abort_o pulse, no done_o. Indices are held for readback.
- Start and abort together in IDLE: abort wins, no start.
- cfg_start_i while busy: ignored.
- Configuration inputs changed mid-sweep: no effect until the next start.
- Asynchronous reset mid-sweep: immediate return to IDLE, all outputs 0. No abort pulse is emitted.
- Counters saturate; none wrap: timeout counter stops at tmo, delay counter at 0.

Decomposition:
- Package asg_seq_pkg: state enum (3-bit, IDLE=0 … FINISH=5), TICK_DIV default, width constants.
- One sub-module, asg_us_tick: prescaler with synchronous restart input, emits a one-cycle tick every TICK_DIV cycles.

Test Plan:
- npts=3, nrep=1, meas_done_i 10 cycles after each start → 3 meas_start_o pulses, point_idx 0,1,2, done_o once, busy_o low afterwards, err_tmo_o=0.
- npts=2, nrep=2, rdly=2 → 4 starts; the gap between the 2nd done and the 3rd start is 250 cycles + FSM overhead (fixed value checked exactly); rep_idx goes 0→1.
- npts=4, tmo=50, meas_done_i never arrives → err_tmo_o set 51 cycles after the first start, meas_abort_o pulse, done_o pulse, point_idx=0. err_tmo_o clears on the next start.
- Abort asserted during DELAY of a 2-repetition sweep → IDLE next cycle, meas_abort_o=1, no done_o, no further meas_start_o.
- meas_wr_i pulses in IDLE and in WAIT of point 5 → only the WAIT pulse produces res_we_o, with res_addr_o=5.
- npts=0 start → done_o two cycles after start, no meas_start_o. Asserting dac_rstn_i low mid-WAIT zeroes all outputs asynchronously.
